regfile_sb: RTL and testbench

Parametrised multi-port integer register file with an integrated busy-bit scoreboard. It generalises the dual-issue register file to N read ports and M write ports, with deterministic write-port priority. It tracks in-flight producers so that the issue stage can detect RAW hazards. It sits between decode/issue (reads, allocates) and writeback (writes, releases).

---
 rtl/regfile_pkg.sv | 10 +
 rtl/sb_tracker.sv | 48 ++++
 rtl/regfile_sb.sv | 84 ++++++++
 tb/tb_regfile_sb.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
// Optional same-cycle read bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;
endpackage

// File: rtl/sb_tracker.sv
// Busy-bit scoreboard: allocate sets, writeback clears, allocate wins a tie.
// busy_cnt is the registered popcount of the next-state busy vector.
module sb_tracker #(
  parameter int NREG = 32,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR-1:0]    al_en,
  input  logic [NWR*AW-1:0] al_addr,
  output logic [NREG-1:0]   busy_vec,
  output logic [AW:0]       busy_cnt
);
  logic [NREG-1:0] set_v, clr_v, busy_nxt;
  logic [AW:0]     cnt_nxt;

  always_comb begin
    set_v    = '0;
    clr_v    = '0;
    busy_nxt = busy_vec;
    cnt_nxt  = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (al_en[j] && al_addr[j*AW +: AW] == AW'(r)) set_v[r] = 1'b1;
        if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) clr_v[r] = 1'b1;
      end
      if (set_v[r])      busy_nxt[r] = 1'b1;
      else if (clr_v[r]) busy_nxt[r] = 1'b0;
    end
    // x0 has no producer ever
    busy_nxt[0] = 1'b0;
    for (int r = 0; r < NREG; r++) cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else if (en) begin
      busy_vec <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// N-read / M-write register file with busy-bit scoreboard; highest write port wins.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 4,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      al_en,
  input  logic [NWR*AW-1:0]   al_addr,
  output logic [NREG-1:0]     busy_vec,
  output logic [AW:0]         busy_cnt
);
  logic [NREG-1:0][XLEN-1:0] regs;

  // Later ports overwrite earlier ones in the loop, giving the highest port priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (en) begin
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] != '0)
          regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
    end
  end

  sb_tracker #(.NREG(NREG), .NWR(NWR)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .al_en    (al_en),
    .al_addr  (al_addr),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rb;
    assign ra = rd_addr[i*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    logic fwd, alc;
    always_comb begin
      rdat = regs[ra];
      rb   = busy_vec[ra];
      fwd  = 1'b0;
      alc  = 1'b0;
      // Only forward writes that will actually commit this edge.
      for (int k = 0; k < NWR; k++) begin
        if (en && !rst && wr_en[k] && wr_addr[k*AW +: AW] == ra && ra != '0) begin
          fwd  = 1'b1;
          rdat = wr_data[k*XLEN +: XLEN];
        end
        if (en && !rst && al_en[k] && al_addr[k*AW +: AW] == ra) alc = 1'b1;
      end
      if (fwd && !alc) rb = 1'b0;
    end
`else
    always_comb begin
      rdat = regs[ra];
      rb   = busy_vec[ra];
    end
`endif

    assign rd_data[i*XLEN +: XLEN] = rdat;
    assign rd_busy[i]              = rb;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: table vectors through a scoreboard queue,
// plus hand sequences for async reset, full scoreboard and same-cycle read.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [19:0]   rd_addr;
  logic [127:0]  rd_data;
  logic [3:0]    rd_busy;
  logic [1:0]    wr_en;
  logic [9:0]    wr_addr;
  logic [63:0]   wr_data;
  logic [1:0]    al_en;
  logic [9:0]    al_addr;
  logic [31:0]   busy_vec;
  logic [5:0]    busy_cnt;

  int checks = 0;
  int failures = 0;

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(4), .NWR(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .al_en(al_en), .al_addr(al_addr),
    .busy_vec(busy_vec), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                en;
    logic [1:0]          we;
    logic [1:0][4:0]     wa;
    logic [1:0][31:0]    wd;
    logic [1:0]          ae;
    logic [1:0][4:0]     aa;
    logic [3:0][4:0]     ra;
    logic [3:0][31:0]    ed;
    logic [3:0]          eb;
    logic [31:0]         ebv;
    logic [5:0]          ecnt;
  } vec_t;

  vec_t vecs[8];
  vec_t exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0;
    al_en = '0;
  endtask

  function automatic vec_t mk(input logic e, input logic [1:0] we,
                              input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic [1:0] ae, input logic [4:0] aa1, input logic [4:0] aa0);
    vec_t v;
    v.en = e; v.we = we; v.wa = {wa1, wa0}; v.wd = {wd1, wd0};
    v.ae = ae; v.aa = {aa1, aa0};
    v.ra = '0; v.ed = '0; v.eb = '0; v.ebv = '0; v.ecnt = '0;
    return v;
  endfunction

  initial begin
    // {inputs} then expected state one edge later; arrays are {port3,port2,port1,port0}
    vecs[0] = mk(1, 2'b11, 7, 32'hBBBB_0002, 7, 32'hAAAA_0001, 2'b00, 0, 0);
    vecs[0].ra = {5'd31, 5'd5, 5'd0, 5'd7};
    vecs[0].ed = {32'h0, 32'h0, 32'h0, 32'hBBBB_0002};

    vecs[1] = mk(1, 2'b01, 0, 0, 0, 32'hDEAD_BEEF, 2'b01, 0, 0);
    vecs[1].ra = {5'd5, 5'd0, 5'd7, 5'd0};
    vecs[1].ed = {32'h0, 32'h0, 32'hBBBB_0002, 32'h0};

    vecs[2] = mk(1, 2'b00, 0, 0, 0, 0, 2'b10, 3, 0);
    vecs[2].ra = {5'd5, 5'd0, 5'd7, 5'd3};
    vecs[2].ed = {32'h0, 32'h0, 32'hBBBB_0002, 32'h0};
    vecs[2].eb = 4'b0001; vecs[2].ebv = 32'h8; vecs[2].ecnt = 1;

    vecs[3] = mk(1, 2'b01, 0, 0, 3, 32'h1234, 2'b01, 0, 3);
    vecs[3].ra = {5'd5, 5'd0, 5'd7, 5'd3};
    vecs[3].ed = {32'h0, 32'h0, 32'hBBBB_0002, 32'h1234};
    vecs[3].eb = 4'b0001; vecs[3].ebv = 32'h8; vecs[3].ecnt = 1;

    vecs[4] = mk(1, 2'b10, 3, 32'h5678, 0, 0, 2'b00, 0, 0);
    vecs[4].ra = {5'd5, 5'd0, 5'd7, 5'd3};
    vecs[4].ed = {32'h0, 32'h0, 32'hBBBB_0002, 32'h5678};

    vecs[5] = mk(0, 2'b01, 0, 0, 4, 32'h1111, 2'b11, 9, 4);
    vecs[5].ra = {5'd7, 5'd3, 5'd9, 5'd4};
    vecs[5].ed = {32'hBBBB_0002, 32'h5678, 32'h0, 32'h0};

    vecs[6] = mk(1, 2'b00, 0, 0, 0, 0, 2'b11, 9, 4);
    vecs[6].ra = {5'd0, 5'd3, 5'd9, 5'd4};
    vecs[6].ed = {32'h0, 32'h5678, 32'h0, 32'h0};
    vecs[6].eb = 4'b0011; vecs[6].ebv = 32'h210; vecs[6].ecnt = 2;

    vecs[7] = mk(1, 2'b11, 9, 32'h99, 4, 32'h44, 2'b01, 0, 9);
    vecs[7].ra = {5'd31, 5'd3, 5'd9, 5'd4};
    vecs[7].ed = {32'h0, 32'h5678, 32'h99, 32'h44};
    vecs[7].eb = 4'b0010; vecs[7].ebv = 32'h200; vecs[7].ecnt = 1;

    rst = 1'b1; en = 1'b0; idle();
    wr_addr = '0; wr_data = '0; al_addr = '0;
    rd_addr = {5'd31, 5'd17, 5'd5, 5'd0};
    #2;
    check("reset_rd_data", rd_data, '0);
    check("reset_rd_busy", {124'h0, rd_busy}, '0);
    check("reset_busy_vec", {96'h0, busy_vec}, '0);
    check("reset_busy_cnt", {122'h0, busy_cnt}, '0);

    @(negedge clk); rst = 1'b0;

    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      en = vecs[n].en; wr_en = vecs[n].we; wr_addr = vecs[n].wa; wr_data = vecs[n].wd;
      al_en = vecs[n].ae; al_addr = vecs[n].aa; rd_addr = vecs[n].ra;
      exp_q.push_back(vecs[n]);
      @(posedge clk); #1;
      idle(); en = 1'b1;
      #1;
      if (exp_q.size() == 0) begin
        check($sformatf("v%0d_queue_empty", n), 1, 0);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        check($sformatf("v%0d_rd_data", n), rd_data, e.ed);
        check($sformatf("v%0d_rd_busy", n), {124'h0, rd_busy}, {124'h0, e.eb});
        check($sformatf("v%0d_busy_vec", n), {96'h0, busy_vec}, {96'h0, e.ebv});
        check($sformatf("v%0d_busy_cnt", n), {122'h0, busy_cnt}, {122'h0, e.ecnt});
      end
    end

    // Async reset between edges, with strobes active.
    @(negedge clk);
    rd_addr = {5'd3, 5'd4, 5'd9, 5'd7};
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h7777};
    #1 rst = 1'b1;
    #1;
    check("midrst_busy_vec", {96'h0, busy_vec}, '0);
    check("midrst_busy_cnt", {122'h0, busy_cnt}, '0);
    check("midrst_rd_data", rd_data, '0);
    idle();
    @(negedge clk); rst = 1'b0;

    // Fill every allocatable register; x0 stays clear so count tops out at 31.
    for (int a = 0; a < 32; a += 2) begin
      @(negedge clk);
      al_en = 2'b11; al_addr = {5'(a + 1), 5'(a)};
    end
    @(negedge clk); idle();
    check("full_busy_vec", {96'h0, busy_vec}, {96'h0, 32'hFFFF_FFFE});
    check("full_busy_cnt", {122'h0, busy_cnt}, 128'd31);
    for (int a = 0; a < 32; a += 2) begin
      @(negedge clk);
      wr_en = 2'b11; wr_addr = {5'(a + 1), 5'(a)}; wr_data = '0;
    end
    @(negedge clk); idle();
    check("drain_busy_vec", {96'h0, busy_vec}, '0);
    check("drain_busy_cnt", {122'h0, busy_cnt}, '0);

    // Same-cycle write/read of x12 while x12 is busy.
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'h0BAD};
    al_en = 2'b10; al_addr = {5'd12, 5'd0};
    @(negedge clk);
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'hCAFE};
    rd_addr = {5'd0, 5'd0, 5'd0, 5'd12};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_data", {96'h0, rd_data[31:0]}, 128'hCAFE);
    check("byp_same_busy", {127'h0, rd_busy[0]}, 128'h0);
`else
    check("byp_same_data", {96'h0, rd_data[31:0]}, 128'h0BAD);
    check("byp_same_busy", {127'h0, rd_busy[0]}, 128'h1);
`endif
    @(posedge clk); #1 idle();
    #1;
    check("byp_next_data", {96'h0, rd_data[31:0]}, 128'hCAFE);
    check("byp_next_busy", {127'h0, rd_busy[0]}, 128'h0);
    check("byp_next_cnt", {122'h0, busy_cnt}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
